// File: rtl/writeback_regfile_pkg.sv
// Shared sizing defaults and constants for the writeback register file slice.
// Latency: n/a (compile-time constants only).
// Backpressure: n/a.
package writeback_regfile_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_REG_CNT = 8;
    localparam int DEF_ADDR_W  = 3;
    localparam int WB_CNT_W    = 16;

    // Architectural zero register: reads 0, never written, never busy.
    localparam int R0_IDX = 0;

endpackage

// File: rtl/writeback_regfile_if.sv
// ID/EX side bundle into the writeback register file: issue, source reads, writeback, status.
// Latency: combinational reads/stall; state-derived outputs move one edge after the cause.
// Backpressure: stall tells ID to hold its issue_* fields; writebacks are never refused.
interface writeback_regfile_if
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic                issue_valid;
    logic [ADDR_W-1:0]   issue_rd;
    logic                issue_wr;
    logic [ADDR_W-1:0]   rs1_addr;
    logic [ADDR_W-1:0]   rs2_addr;
    logic [DATA_W-1:0]   rs1_data;
    logic [DATA_W-1:0]   rs2_data;
    logic                stall;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic [WB_CNT_W-1:0] wb_count;
    logic                err;

    // Pipeline side: ID drives issue/reads, EX drives writeback.
    modport master (
        output issue_valid, issue_rd, issue_wr, rs1_addr, rs2_addr,
        output wb_valid, wb_rd, wb_data,
        input  rs1_data, rs2_data, stall, wb_count, err
    );

    // Register file side.
    modport slave (
        input  issue_valid, issue_rd, issue_wr, rs1_addr, rs2_addr,
        input  wb_valid, wb_rd, wb_data,
        output rs1_data, rs2_data, stall, wb_count, err
    );

endinterface

// File: rtl/writeback_regfile_scoreboard.sv
// Busy scoreboard: tracks in-flight destinations, flags RAW/WAW hazards and writebacks to idle registers.
// Latency: haz is combinational; busy/err update on the next rising edge.
// Backpressure: haz feeds ID stall; an issue is only recorded when it is not hazarded. WB_BYPASS_EN waives matched hazards.
module wb_scoreboard
    import writeback_regfile_pkg::*;
#(
    parameter int REG_CNT = DEF_REG_CNT,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_wr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              haz,
    output logic              err
);

    logic [REG_CNT-1:0] busy_q, busy_d;
    logic               err_q, err_d;
    logic               src1_haz, src2_haz, waw_haz;
    logic               issue_set, wb_clr;

    // Hazard terms; a result arriving this cycle can satisfy a waiting operand when forwarding is built in.
    always_comb begin
        src1_haz = busy_q[rs1_addr];
        src2_haz = busy_q[rs2_addr];
        waw_haz  = issue_wr & busy_q[issue_rd];
`ifdef WB_BYPASS_EN
        if (wb_valid && (wb_rd == rs1_addr)) src1_haz = 1'b0;
        if (wb_valid && (wb_rd == rs2_addr)) src2_haz = 1'b0;
        if (wb_valid && (wb_rd == issue_rd)) waw_haz  = 1'b0;
`endif
        haz = src1_haz | src2_haz | waw_haz;
    end

    // Next busy vector and sticky error; on a same-register collision the issue's set wins over the clear.
    always_comb begin
        issue_set = issue_valid & ~haz & issue_wr & (issue_rd != ADDR_W'(R0_IDX));
        wb_clr    = wb_valid & (wb_rd != ADDR_W'(R0_IDX));
        busy_d    = busy_q;
        err_d     = err_q | (wb_clr & ~busy_q[wb_rd]);
        if (wb_clr)    busy_d[wb_rd]    = 1'b0;
        if (issue_set) busy_d[issue_rd] = 1'b1;
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/writeback_regfile.sv
// Writeback end of the pipeline: commits EX results to the register file and serves ID's two source reads.
// Latency: writes visible one cycle after wb_valid (same cycle with WB_BYPASS_EN); reads and stall are combinational.
// Backpressure: stall = issue_valid & hazard holds ID; writebacks always complete. Optional forwarding macro: WB_BYPASS_EN.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_CNT = DEF_REG_CNT,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    writeback_regfile_if.slave  bus
);

    logic [DATA_W-1:0]   regs_q [REG_CNT];
    logic [DATA_W-1:0]   regs_d [REG_CNT];
    logic [WB_CNT_W-1:0] wb_count_q, wb_count_d;
    logic                haz;
    logic                wb_commit;

    // r0 writebacks count but never reach the array.
    assign wb_commit = bus.wb_valid & (bus.wb_rd != ADDR_W'(R0_IDX));

    wb_scoreboard #(
        .REG_CNT (REG_CNT),
        .ADDR_W  (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_wr    (bus.issue_wr),
        .rs1_addr    (bus.rs1_addr),
        .rs2_addr    (bus.rs2_addr),
        .wb_valid    (bus.wb_valid),
        .wb_rd       (bus.wb_rd),
        .haz         (haz),
        .err         (bus.err)
    );

    // Register array write and writeback counter (wraps naturally at its width).
    always_comb begin
        regs_d     = regs_q;
        wb_count_d = wb_count_q;
        if (bus.wb_valid) begin
            wb_count_d = wb_count_q + WB_CNT_W'(1);
        end
        if (wb_commit) begin
            regs_d[bus.wb_rd] = bus.wb_data;
        end
    end

    // Array and counter state; reset clears every register including r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            wb_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wb_count_q <= wb_count_d;
        end
    end

    // Source read mux with optional same-cycle forwarding of the incoming result.
    always_comb begin
        bus.rs1_data = regs_q[bus.rs1_addr];
        bus.rs2_data = regs_q[bus.rs2_addr];
`ifdef WB_BYPASS_EN
        if (wb_commit && (bus.wb_rd == bus.rs1_addr)) bus.rs1_data = bus.wb_data;
        if (wb_commit && (bus.wb_rd == bus.rs2_addr)) bus.rs2_data = bus.wb_data;
`endif
        if (bus.rs1_addr == ADDR_W'(R0_IDX)) bus.rs1_data = '0;
        if (bus.rs2_addr == ADDR_W'(R0_IDX)) bus.rs2_data = '0;
    end

    assign bus.stall    = bus.issue_valid & haz;
    assign bus.wb_count = wb_count_q;

endmodule
